// File: rtl/ysyx_22051468_ifu_pcgen.sv
// Instruction-fetch front end: owns the PC and keeps at most one imem fetch in flight.
// It presents {inst, pc, valid} to IF/ID, and a redirect flushes the slot and squashes any in-flight fetch.
module ysyx_22051468_ifu_pcgen #(
  parameter int                     WIDTH      = 64,
  parameter int                     INST_WIDTH = 32,
  parameter logic [WIDTH-1:0]       RESET_PC   = WIDTH'(64'h8000_0000),
  parameter logic [INST_WIDTH-1:0]  INST_NOP   = INST_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold_pipeline,
  input  logic                  redirect_valid,
  input  logic [WIDTH-1:0]      redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [WIDTH-1:0]      imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [WIDTH-1:0]      inst_addr_o,
  output logic                  inst_valid_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] fetch_pc;
  logic             drop;
  logic             req_fire;

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // NOTE: all state updates use non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      fetch_pc     <= RESET_PC;
      drop         <= 1'b0;
      inst_o       <= INST_NOP;
      inst_addr_o  <= RESET_PC;
      inst_valid_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (redirect_valid) pc <= redirect_pc;
          state <= REQ;
        end

        REQ: begin
          if (req_fire) begin
            fetch_pc <= pc;
            state    <= WAIT;
          end
          // A redirect on the handshake cycle must squash the fetch that was just accepted.
          if (redirect_valid) begin
            pc   <= redirect_pc;
            drop <= req_fire;
          end
        end

        WAIT: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
            if (imem_rsp_valid) begin
              drop  <= 1'b0;
              state <= REQ;
            end else begin
              drop  <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= REQ;
            end else begin
              inst_o       <= imem_rsp_data;
              inst_addr_o  <= fetch_pc;
              inst_valid_o <= 1'b1;
              pc           <= pc + WIDTH'(4);
              state        <= FULL;
            end
          end
        end

        FULL: begin
          if (redirect_valid || !hold_pipeline) begin
            inst_o       <= INST_NOP;
            inst_valid_o <= 1'b0;
            state        <= REQ;
          end
          if (redirect_valid) pc <= redirect_pc;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22051468_ifu_pcgen.sv
// Directed bench for ysyx_22051468_ifu_pcgen: a bench-side PC model and a scoreboard queue
// supply every expected value, and each check is an immediate assertion.
module tb_ysyx_22051468_ifu_pcgen;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold_pipeline;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] inst_o;
  logic [63:0] inst_addr_o;
  logic        inst_valid_o;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t last_exp;
  logic [63:0] model_pc;

  ysyx_22051468_ifu_pcgen dut (
    .clk            (clk),
    .rst            (rst),
    .hold_pipeline  (hold_pipeline),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_o         (inst_o),
    .inst_addr_o    (inst_addr_o),
    .inst_valid_o   (inst_valid_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " valid"},     64'(inst_valid_o),   64'd0);
    chk({tag, " inst"},      64'(inst_o),         64'(NOP));
    chk({tag, " inst_addr"}, inst_addr_o,         RESET_PC);
    chk({tag, " req_valid"}, 64'(imem_req_valid), 64'd0);
    chk({tag, " req_addr"},  imem_req_addr,       RESET_PC);
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (!imem_req_valid && k < 20) begin
      tick();
      k++;
    end
    chk({tag, " req wait"}, 64'(imem_req_valid), 64'd1);
  endtask

  task automatic pop_check(input string tag);
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      last_exp = sb.pop_front();
      chk({tag, " valid"},     64'(inst_valid_o), 64'd1);
      chk({tag, " inst_addr"}, inst_addr_o,       last_exp.addr);
      chk({tag, " inst"},      64'(inst_o),       64'(last_exp.inst));
    end
  endtask

  // Fetch from REQ: handshake, wait `delay` cycles in WAIT, respond, then check the FULL slot.
  task automatic fetch(input logic [31:0] inst, input int delay, input string tag);
    chk({tag, " req_valid"}, 64'(imem_req_valid), 64'd1);
    chk({tag, " req_addr"},  imem_req_addr,       model_pc);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < delay; i++) begin
      chk({tag, " wait valid"},     64'(inst_valid_o),   64'd0);
      chk({tag, " wait req_valid"}, 64'(imem_req_valid), 64'd0);
      tick();
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = inst;
    sb.push_back('{addr: model_pc, inst: inst});
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom();
    model_pc = model_pc + 64'd4;
    pop_check(tag);
  endtask

  // Drop hold in FULL: the slot empties and the next request goes out at the model PC.
  task automatic consume(input string tag);
    hold_pipeline = 1'b0;
    tick();
    chk({tag, " cons valid"},     64'(inst_valid_o),   64'd0);
    chk({tag, " cons inst"},      64'(inst_o),         64'(NOP));
    chk({tag, " cons req_valid"}, 64'(imem_req_valid), 64'd1);
    chk({tag, " cons req_addr"},  imem_req_addr,       model_pc);
  endtask

  initial begin
    rst            = 1'b1;
    hold_pipeline  = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    model_pc       = RESET_PC;

    repeat (2) tick();
    chk_reset("reset");
    rst = 1'b0;

    // 1: first fetch after reset with a one-cycle response
    wait_req("t1");
    fetch(32'h0010_0093, 0, "t1");
    consume("t1");

    // 2: hold for five cycles in FULL
    hold_pipeline = 1'b1;
    fetch(32'h0020_0113, 1, "t2");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2 hold valid",     64'(inst_valid_o),   64'd1);
      chk("t2 hold inst",      64'(inst_o),         64'(last_exp.inst));
      chk("t2 hold inst_addr", inst_addr_o,         last_exp.addr);
      chk("t2 hold req_valid", 64'(imem_req_valid), 64'd0);
    end
    consume("t2");

    // 3: redirect while WAIT, late response is discarded
    chk("t3 req_addr", imem_req_addr, model_pc);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1000;
    tick();
    redirect_valid = 1'b0;
    model_pc       = 64'h8000_1000;
    for (int i = 0; i < 2; i++) begin
      chk("t3 wait valid",     64'(inst_valid_o),   64'd0);
      chk("t3 wait req_valid", 64'(imem_req_valid), 64'd0);
      tick();
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hdead_beef;
    tick();
    imem_rsp_valid = 1'b0;
    chk("t3 drop valid",     64'(inst_valid_o),   64'd0);
    chk("t3 drop req_valid", 64'(imem_req_valid), 64'd1);
    chk("t3 drop req_addr",  imem_req_addr,       model_pc);

    // 4: redirect in FULL with hold asserted flushes the slot
    hold_pipeline = 1'b1;
    fetch(32'h0030_0193, 0, "t4");
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2000;
    tick();
    redirect_valid = 1'b0;
    model_pc       = 64'h8000_2000;
    chk("t4 flush valid",     64'(inst_valid_o),   64'd0);
    chk("t4 flush inst",      64'(inst_o),         64'(NOP));
    chk("t4 flush req_valid", 64'(imem_req_valid), 64'd1);
    chk("t4 flush req_addr",  imem_req_addr,       model_pc);
    hold_pipeline = 1'b0;

    // 5: request back-pressure, then redirect and response on the same WAIT cycle
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5 stall req_valid", 64'(imem_req_valid), 64'd1);
      chk("t5 stall req_addr",  imem_req_addr,       model_pc);
      chk("t5 stall valid",     64'(inst_valid_o),   64'd0);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("t5 wait req_valid", 64'(imem_req_valid), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_3000;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hbad0_0bad;
    tick();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    model_pc       = 64'h8000_3000;
    chk("t5 both valid",     64'(inst_valid_o),   64'd0);
    chk("t5 both req_valid", 64'(imem_req_valid), 64'd1);
    chk("t5 both req_addr",  imem_req_addr,       model_pc);
    fetch(32'h0040_0213, 2, "t5b");
    consume("t5b");

    // 6: PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    model_pc       = 64'hFFFF_FFFF_FFFF_FFFC;
    chk("t6 redirect req_addr", imem_req_addr, model_pc);
    fetch(32'h0050_0293, 0, "t6");
    consume("t6");
    chk("t6 wrap addr", imem_req_addr, 64'd0);

    // 6b: reset asserted mid-fetch, then a stray response after release
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_reset("t6 async reset");
    tick();
    rst            = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    tick();
    tick();
    imem_rsp_valid = 1'b0;
    model_pc       = RESET_PC;
    chk("t6 stray valid",     64'(inst_valid_o),   64'd0);
    chk("t6 stray inst",      64'(inst_o),         64'(NOP));
    chk("t6 stray req_valid", 64'(imem_req_valid), 64'd1);
    chk("t6 stray req_addr",  imem_req_addr,       model_pc);
    fetch(32'h0060_0313, 0, "t6c");
    consume("t6c");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
